// File: rtl/apb_master.sv
// APB requester: single-beat valid/ready commands in, APB setup/access transfers out.
// Define APB_MASTER_TIMEOUT_EN to abort access phases that stall for TIMEOUT cycles.
module apb_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state_q, state_d;
  logic       accept;
  logic       done;
  logic       abort;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:   if (cmd_valid) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = IDLE;
          done    = 1'b1;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // This edge would be the TIMEOUT-th stalled one; PREADY above takes priority.
        else if (wait_cnt_q == TimeoutLast) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      PSEL      <= (state_d != IDLE);
      PENABLE   <= (state_d == ACCESS);
      rsp_valid <= done | abort;
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (done | abort) begin
        rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_timeout <= abort;
      if (state_q == SETUP) begin
        wait_cnt_q <= '0;
      end else if (state_q == ACCESS && !PREADY) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small APB memory model with programmable wait states.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: memory plus a wait-state counter loaded during SETUP.
  logic [7:0] mem [256];
  logic [7:0] stall = 8'd0;
  logic       stuck = 1'b0;
  logic [7:0] wcnt = 8'd0;

  assign PRDATA = mem[PADDR];
  assign PREADY = !stuck && (wcnt == 8'd0);

  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) wcnt <= stall;
    else if (PSEL && PENABLE && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last do_xfer call.
  logic       r_got, r_tmo, r_stable, r_ready_early;
  logic [7:0] r_rdata;
  int         r_lat, r_psel, r_pen;

  // Issue one command from IDLE; r_lat counts edges after the accepting edge until rsp_valid.
  task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int maxc);
    r_got = 0; r_tmo = 0; r_stable = 1; r_ready_early = 0; r_rdata = '0;
    r_lat = 0; r_psel = 0; r_pen = 0;
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rsp_valid) begin
        r_got = 1; r_rdata = rsp_rdata; r_tmo = rsp_timeout;
        break;
      end
      if (PSEL) r_psel++;
      if (PENABLE) r_pen++;
      if (PSEL && (PADDR != addr || PWRITE != wr || (wr && PWDATA != wdata))) r_stable = 0;
      if (cmd_ready || !busy) r_ready_early = 1;
      @(posedge PCLK); #1;
      r_lat++;
    end
    if (r_got) begin
      @(posedge PCLK); #1;
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    end
  endtask

  logic [7:0] b2b_data [3] = '{8'h11, 8'h22, 8'h33};
  int         set_cyc [3];
  logic [7:0] set_addr [3];
  int         nset, nrsp;
  logic       seen;

  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Zero-wait write; rsp_valid occupies the third cycle counted from the accepting edge.
    do_xfer(1'b1, 8'h05, 8'hA5, 50);
    check("wr_got", 32'(r_got), 32'd1);
    check("wr_lat", 32'(r_lat), 32'd2);
    check("wr_psel_cycles", 32'(r_psel), 32'd2);
    check("wr_pen_cycles", 32'(r_pen), 32'd1);
    check("wr_stable", 32'(r_stable), 32'd1);
    check("wr_rdata", 32'(r_rdata), 32'd0);
    check("wr_tmo", 32'(r_tmo), 32'd0);
    check("wr_ready_low", 32'(r_ready_early), 32'd0);

    do_xfer(1'b0, 8'h05, 8'h00, 50);
    check("rd_got", 32'(r_got), 32'd1);
    check("rd_lat", 32'(r_lat), 32'd2);
    check("rd_rdata", 32'(r_rdata), 32'hA5);
    check("rd_stable", 32'(r_stable), 32'd1);

    // Four wait states on a read of 0x10.
    do_xfer(1'b1, 8'h10, 8'h3C, 50);
    stall = 8'd4;
    do_xfer(1'b0, 8'h10, 8'h00, 50);
    stall = 8'd0;
    check("ws_lat", 32'(r_lat), 32'd6);
    check("ws_pen_cycles", 32'(r_pen), 32'd5);
    check("ws_stable", 32'(r_stable), 32'd1);
    check("ws_rdata", 32'(r_rdata), 32'h3C);
    check("ws_ready_low", 32'(r_ready_early), 32'd0);

    // Back-to-back writes with cmd_valid held high.
    nset = 0; nrsp = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = b2b_data[0];
    for (int i = 0; i < 40 && (nset < 3 || nrsp < 3); i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid) nrsp++;
      if (PSEL && !PENABLE && nset < 3) begin
        set_cyc[nset] = i; set_addr[nset] = PADDR; nset++;
        if (nset < 3) begin
          cmd_addr = 8'(nset + 1); cmd_wdata = b2b_data[nset];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    check("b2b_setups", 32'(nset), 32'd3);
    check("b2b_rsps", 32'(nrsp), 32'd3);
    check("b2b_gap01", 32'(set_cyc[1] - set_cyc[0]), 32'd3);
    check("b2b_gap12", 32'(set_cyc[2] - set_cyc[1]), 32'd3);
    check("b2b_addr0", 32'(set_addr[0]), 32'h01);
    check("b2b_addr1", 32'(set_addr[1]), 32'h02);
    check("b2b_addr2", 32'(set_addr[2]), 32'h03);
    @(posedge PCLK); #1;
    do_xfer(1'b0, 8'h01, 8'h00, 50);
    check("b2b_rd1", 32'(r_rdata), 32'h11);
    do_xfer(1'b0, 8'h02, 8'h00, 50);
    check("b2b_rd2", 32'(r_rdata), 32'h22);
    do_xfer(1'b0, 8'h03, 8'h00, 50);
    check("b2b_rd3", 32'(r_rdata), 32'h33);

    // Reset during ACCESS drops the transfer.
    stall = 8'd10;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge PCLK); #1;
      seen = PENABLE;
    end
    check("rst_mid_access_reached", 32'(seen), 32'd1);
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", 32'(PSEL), 32'd0);
    check("rst_mid_penable", 32'(PENABLE), 32'd0);
    check("rst_mid_paddr", 32'(PADDR), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    stall = 8'd0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);

    // Slave never ready.
    stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer(1'b0, 8'h20, 8'h00, 100);
    stuck = 1'b0;
    check("tmo_got", 32'(r_got), 32'd1);
    check("tmo_flag", 32'(r_tmo), 32'd1);
    check("tmo_rdata", 32'(r_rdata), 32'd0);
    check("tmo_lat", 32'(r_lat), 32'd17);
    check("tmo_ready_after", 32'(cmd_ready), 32'd1);
`else
    do_xfer(1'b0, 8'h20, 8'h00, 100);
    check("stuck_no_rsp", 32'(r_got), 32'd0);
    check("stuck_still_access", 32'(PENABLE), 32'd1);
    stuck = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid) begin
        seen = 1'b1;
        check("stuck_release_tmo", 32'(rsp_timeout), 32'd0);
      end
    end
    check("stuck_release_rsp", 32'(seen), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
